// File: rtl/ulpi_rx_framer.sv
// ULPI receive framer: frames USB packets from the classified PHY->link stream, checks PID/CRC.
// Optional ULPI_RX_LINESTATE_EN adds linestate/vbus_state/linestate_chg outputs from RX CMD [3:0].
`timescale 1ns/1ps
module ulpi_rx_framer #(
  parameter int MAX_LEN = 1027,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_dir,
  input  logic             rx_cmd_valid,
  input  logic             rx_data_valid,
  input  logic [7:0]       rx_data,
  output logic [7:0]       pkt_data,
  output logic             pkt_valid,
  output logic             pkt_first,
  output logic             pkt_last,
  output logic [LEN_W-1:0] pkt_len,
  output logic             pkt_pid_err,
  output logic             pkt_crc_err,
  output logic             pkt_rx_err,
  output logic             pkt_oversize,
  output logic             rx_active,
`ifdef ULPI_RX_LINESTATE_EN
  output logic [1:0]       linestate,
  output logic [1:0]       vbus_state,
  output logic             linestate_chg,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: none. Every rx byte/command is consumed in the cycle it is presented and every
  // pkt_valid pulse lasts exactly one cycle; there is no ready in either direction.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PID = 2'd1,
    DATA     = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_THREE = LEN_W'(3);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_SAT   = LEN_W'(MAX_LEN + 1);

  state_t            state, state_n;
  logic              data_in, cmd_in, ev_active, ev_error, ev_start, end_ev;
  logic              accept, flush, restart, keep;
  logic [7:0]        hold_data, pid_q;
  logic              hold_valid, hold_first;
  logic [LEN_W-1:0]  cnt;
  logic              err_q, ovs_q;
  logic [4:0]        crc5_q;
  logic [15:0]       crc16_q;
  logic              pid_bad, crc_bad;

  // Reflected (LSB-first) bytewise CRC updates.
  function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 5'h14;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // A data byte wins over a simultaneous RX CMD; dir low ends any packet in flight.
  assign data_in   = rx_dir & rx_data_valid;
  assign cmd_in    = rx_dir & rx_cmd_valid & ~rx_data_valid;
  assign ev_active = cmd_in & rx_data[4];
  assign ev_error  = cmd_in & (rx_data[5:4] == 2'b11);
  assign ev_start  = cmd_in & (rx_data[5:4] == 2'b01);
  assign end_ev    = ~rx_dir | (cmd_in & ~rx_data[4]);
  assign keep      = accept & (cnt < LEN_MAX);
  assign state_dbg = state;

  // A plain RxActive command inside a packet means the PHY started a new one without an end.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    flush   = 1'b0;
    restart = 1'b0;
    case (state)
      IDLE: begin
        if (ev_active) begin
          state_n = WAIT_PID;
          restart = 1'b1;
        end
      end
      WAIT_PID: begin
        if (data_in) begin
          accept  = 1'b1;
          state_n = DATA;
        end else if (end_ev) begin
          state_n = IDLE;
        end else if (ev_start) begin
          restart = 1'b1;
        end
      end
      DATA: begin
        if (data_in) begin
          accept = 1'b1;
        end else if (end_ev) begin
          flush   = 1'b1;
          state_n = IDLE;
        end else if (ev_start) begin
          flush   = 1'b1;
          restart = 1'b1;
          state_n = WAIT_PID;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // End-of-packet status from the PID class; residuals are the reflected-register forms.
  always_comb begin
    pid_bad = (pid_q[7:4] != ~pid_q[3:0]);
    crc_bad = 1'b0;
    case (pid_q[1:0])
      2'b01:   crc_bad = (cnt != LEN_THREE) | (crc5_q != 5'b00110);
      2'b11:   crc_bad = (cnt < LEN_THREE) | (crc16_q != 16'hB001);
      2'b10:   crc_bad = (cnt != LEN_ONE);
      default: crc_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pkt_data     <= '0;
      pkt_valid    <= 1'b0;
      pkt_first    <= 1'b0;
      pkt_last     <= 1'b0;
      pkt_len      <= '0;
      pkt_pid_err  <= 1'b0;
      pkt_crc_err  <= 1'b0;
      pkt_rx_err   <= 1'b0;
      pkt_oversize <= 1'b0;
      rx_active    <= 1'b0;
      hold_data    <= '0;
      hold_valid   <= 1'b0;
      hold_first   <= 1'b0;
      pid_q        <= '0;
      cnt          <= '0;
      err_q        <= 1'b0;
      ovs_q        <= 1'b0;
      crc5_q       <= 5'h1F;
      crc16_q      <= 16'hFFFF;
    end else begin
      state     <= state_n;
      pkt_valid <= 1'b0;
      pkt_first <= 1'b0;
      pkt_last  <= 1'b0;
      if (cmd_in) rx_active <= rx_data[4];

      if (keep && hold_valid) begin
        pkt_valid <= 1'b1;
        pkt_data  <= hold_data;
        pkt_first <= hold_first;
      end

      if (flush && hold_valid) begin
        pkt_valid    <= 1'b1;
        pkt_data     <= hold_data;
        pkt_first    <= hold_first;
        pkt_last     <= 1'b1;
        pkt_len      <= cnt;
        pkt_pid_err  <= pid_bad;
        pkt_crc_err  <= crc_bad;
        pkt_rx_err   <= err_q;
        pkt_oversize <= ovs_q;
        hold_valid   <= 1'b0;
      end

      if (restart) begin
        cnt        <= '0;
        err_q      <= ev_error;
        ovs_q      <= 1'b0;
        crc5_q     <= 5'h1F;
        crc16_q    <= 16'hFFFF;
        hold_valid <= 1'b0;
      end else begin
        if (ev_error) err_q <= 1'b1;
        if (accept) begin
          if (cnt != LEN_SAT) cnt <= cnt + LEN_ONE;
          if (!keep) ovs_q <= 1'b1;
        end
        if (keep) begin
          hold_data  <= rx_data;
          hold_valid <= 1'b1;
          hold_first <= (cnt == '0);
          if (cnt == '0) begin
            pid_q <= rx_data;
          end else begin
            crc5_q  <= crc5_byte(crc5_q, rx_data);
            crc16_q <= crc16_byte(crc16_q, rx_data);
          end
        end
      end
    end
  end

`ifdef ULPI_RX_LINESTATE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      linestate     <= 2'b00;
      vbus_state    <= 2'b00;
      linestate_chg <= 1'b0;
    end else begin
      linestate_chg <= 1'b0;
      if (cmd_in) begin
        linestate     <= rx_data[1:0];
        vbus_state    <= rx_data[3:2];
        linestate_chg <= (rx_data[1:0] != linestate);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Self-checking bench for ulpi_rx_framer: expected pulses are queued as packets are driven
// and compared as the framer emits them.
`timescale 1ns/1ps
module tb_ulpi_rx_framer;
  localparam int MAX_LEN = 1027;
  localparam int LEN_W   = 11;
  localparam int W       = 26;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_dir, rx_cmd_valid, rx_data_valid;
  logic [7:0]       rx_data;
  logic [7:0]       pkt_data;
  logic             pkt_valid, pkt_first, pkt_last;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_pid_err, pkt_crc_err, pkt_rx_err, pkt_oversize, rx_active;
  logic [1:0]       state_dbg;
`ifdef ULPI_RX_LINESTATE_EN
  logic [1:0]       linestate, vbus_state;
  logic             linestate_chg;
`endif

  // Expected word: [7:0] data, [8] first, [9] last, [20:10] len, [21] pid_err,
  // [22] crc_err, [23] rx_err, [24] oversize, [25] crc_err is checked.
  logic [W-1:0] exp_q[$];
  logic [7:0]   tx_q[$];
  logic [W-1:0] mon_e;
  int           n_vec = 0;
  int           n_err = 0;

  ulpi_rx_framer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .rx_dir(rx_dir), .rx_cmd_valid(rx_cmd_valid),
    .rx_data_valid(rx_data_valid), .rx_data(rx_data), .pkt_data(pkt_data),
    .pkt_valid(pkt_valid), .pkt_first(pkt_first), .pkt_last(pkt_last), .pkt_len(pkt_len),
    .pkt_pid_err(pkt_pid_err), .pkt_crc_err(pkt_crc_err), .pkt_rx_err(pkt_rx_err),
    .pkt_oversize(pkt_oversize), .rx_active(rx_active),
`ifdef ULPI_RX_LINESTATE_EN
    .linestate(linestate), .vbus_state(vbus_state), .linestate_chg(linestate_chg),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected pulses outstanding", exp_q.size());
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop on every output pulse.
  always @(negedge clk) begin
    if (!reset && pkt_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'(pkt_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data", 32'(pkt_data), 32'(mon_e[7:0]));
        check("first", 32'(pkt_first), 32'(mon_e[8]));
        check("last", 32'(pkt_last), 32'(mon_e[9]));
        if (mon_e[9]) begin
          check("len", 32'(pkt_len), 32'(mon_e[20:10]));
          check("pid_err", 32'(pkt_pid_err), 32'(mon_e[21]));
          if (mon_e[25]) check("crc_err", 32'(pkt_crc_err), 32'(mon_e[22]));
          check("rx_err", 32'(pkt_rx_err), 32'(mon_e[23]));
          check("oversize", 32'(pkt_oversize), 32'(mon_e[24]));
        end
      end
    end
  end

  // Driver tasks: inputs change on the falling edge.
  task automatic drive(input logic dir, input logic cv, input logic dv, input logic [7:0] d);
    @(negedge clk);
    rx_dir = dir; rx_cmd_valid = cv; rx_data_valid = dv; rx_data = d;
  endtask
  task automatic put_cmd(input logic [7:0] c);  drive(1'b1, 1'b1, 1'b0, c); endtask
  task automatic put_byte(input logic [7:0] b); drive(1'b1, 1'b0, 1'b1, b); endtask
  task automatic put_idle();                    drive(1'b1, 1'b0, 1'b0, 8'h00); endtask
  task automatic put_quiet();                   drive(1'b0, 1'b0, 1'b0, 8'h00); endtask

  task automatic push_exp(input logic [7:0] d, input logic first, input logic last, input int len,
                          input logic pid, input logic crc, input logic chk, input logic rxe,
                          input logic ovs);
    logic [W-1:0] e;
    e = '0;
    e[7:0] = d; e[8] = first; e[9] = last;
    if (last) begin
      e[20:10] = LEN_W'(len); e[21] = pid; e[22] = crc; e[23] = rxe; e[24] = ovs; e[25] = chk;
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  // Builds PID + random payload + complemented CRC16, optionally with one flipped payload bit.
  task automatic build_data(input logic [7:0] pid, input int plen, input logic corrupt);
    logic [15:0] crc;
    logic [7:0]  b;
    int          idx;
    tx_q.delete();
    tx_q.push_back(pid);
    crc = 16'hFFFF;
    for (int i = 0; i < plen; i++) begin
      b = 8'($urandom_range(0, 255));
      tx_q.push_back(b);
      crc = crc16_upd(crc, b);
    end
    tx_q.push_back(~crc[7:0]);
    tx_q.push_back(~crc[15:8]);
    if (corrupt) begin
      idx = $urandom_range(1, plen);
      tx_q[idx] = tx_q[idx] ^ (8'd1 << $urandom_range(0, 7));
    end
  endtask

  task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input int n);
    tx_q.delete();
    tx_q.push_back(a);
    if (n > 1) tx_q.push_back(b);
    if (n > 2) tx_q.push_back(c);
  endtask

  // end_kind: 0 RX CMD inactive, 1 dir drops, 2 HostDisconnect.
  task automatic frame(input logic exp_crc, input logic chk_crc, input logic rx_err_mid,
                       input int end_kind, input logic gaps);
    int   n, kept;
    logic pid_bad;
    n       = tx_q.size();
    kept    = (n > MAX_LEN) ? MAX_LEN : n;
    pid_bad = (tx_q[0][7:4] != ~tx_q[0][3:0]);
    for (int i = 0; i < kept; i++)
      push_exp(tx_q[i], i == 0, i == kept - 1, (n > MAX_LEN) ? MAX_LEN + 1 : n,
               pid_bad, exp_crc, chk_crc, rx_err_mid, n > MAX_LEN);
    put_cmd(8'h10);
    for (int i = 0; i < n; i++) begin
      put_byte(tx_q[i]);
      if (gaps && $urandom_range(0, 3) == 0) put_idle();
      if (rx_err_mid && i == 0) put_cmd(8'h31);
    end
    if (end_kind == 1)      put_quiet();
    else if (end_kind == 2) put_cmd(8'h20);
    else                    put_cmd(8'h00);
    repeat (3) put_quiet();
  endtask

  initial begin
    reset = 1'b1;
    rx_dir = 1'b0; rx_cmd_valid = 1'b0; rx_data_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pkt_valid), 32'd0);
    check("rst_last", 32'(pkt_last), 32'd0);
    check("rst_data", 32'(pkt_data), 32'd0);
    check("rst_len", 32'(pkt_len), 32'd0);
    check("rst_crc_err", 32'(pkt_crc_err), 32'd0);
    check("rst_rx_active", 32'(rx_active), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    repeat (2) put_quiet();

    // Handshake single byte; tokens good and bad.
    set3(8'hD2, 8'h00, 8'h00, 1); frame(1'b0, 1'b1, 1'b0, 0, 1'b0);
    set3(8'h69, 8'h00, 8'h10, 3); frame(1'b0, 1'b1, 1'b0, 0, 1'b0);
    set3(8'h69, 8'h00, 8'h11, 3); frame(1'b1, 1'b1, 1'b0, 0, 1'b0);
    set3(8'h2D, 8'h00, 8'h10, 3); frame(1'b0, 1'b1, 1'b0, 2, 1'b1);
    // Zero-length DATA0, truncated DATA0, bad PID, RxError mid-stream.
    set3(8'hC3, 8'h00, 8'h00, 3); frame(1'b0, 1'b1, 1'b0, 0, 1'b0);
    set3(8'hC3, 8'h00, 8'h00, 1); frame(1'b1, 1'b1, 1'b0, 0, 1'b0);
    set3(8'hD3, 8'h00, 8'h00, 1); frame(1'b1, 1'b1, 1'b0, 0, 1'b0);
    build_data(8'hC3, 4, 1'b0);   frame(1'b0, 1'b1, 1'b1, 0, 1'b0);
    // Token cut short by dir dropping.
    set3(8'h2D, 8'h00, 8'h00, 2); frame(1'b1, 1'b1, 1'b0, 1, 1'b0);

    // RxActive then end with no bytes: no output.
    put_cmd(8'h10); put_idle();
    check("rx_active_on", 32'(rx_active), 32'd1);
    check("state_wait_pid", 32'(state_dbg), 32'd1);
    put_cmd(8'h00); put_idle();
    check("rx_active_off", 32'(rx_active), 32'd0);
    check("state_idle", 32'(state_dbg), 32'd0);

    // Data bytes arriving with rx_cmd_valid also high.
    push_exp(8'hC3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(8'h00, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    put_cmd(8'h10); put_byte(8'hC3);
    drive(1'b1, 1'b1, 1'b1, 8'h00); drive(1'b1, 1'b1, 1'b1, 8'h00);
    put_cmd(8'h00); repeat (3) put_quiet();

    // New RxActive inside DATA closes the current packet and opens the next.
    push_exp(8'h4B, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(8'h01, 1'b0, 1'b1, 2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push_exp(8'hD2, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    put_cmd(8'h10); put_byte(8'h4B); put_byte(8'h01);
    put_cmd(8'h10); put_byte(8'hD2); put_cmd(8'h00);
    repeat (3) put_quiet();

    // Reset mid DATA1: only the byte already pushed out is seen.
    push_exp(8'h4B, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put_cmd(8'h10); put_byte(8'h4B); put_byte(8'h01); put_idle(); put_idle();
    @(posedge clk); #2 reset = 1'b1;
    rx_dir = 1'b0; rx_cmd_valid = 1'b0; rx_data_valid = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(pkt_valid), 32'd0);
    check("midrst_last", 32'(pkt_last), 32'd0);
    check("midrst_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #2 reset = 1'b0;
    repeat (3) put_quiet();
    set3(8'hD2, 8'h00, 8'h00, 1); frame(1'b0, 1'b1, 1'b0, 0, 1'b0);

    // Random DATA0/DATA1 packets, some with a corrupted payload bit.
    for (int k = 0; k < 10; k++) begin
      logic corrupt;
      int   plen;
      plen    = $urandom_range(1, 16);
      corrupt = (k % 3 == 2);
      build_data((k % 2 == 0) ? 8'hC3 : 8'h4B, plen, corrupt);
      frame(corrupt, 1'b1, 1'b0, $urandom_range(0, 2), 1'b1);
    end

    // Exactly MAX_LEN bytes, then MAX_LEN+2 bytes.
    build_data(8'h4B, MAX_LEN - 3, 1'b0);
    frame(1'b0, 1'b1, 1'b0, 0, 1'b0);
    build_data(8'hC3, MAX_LEN - 3, 1'b0);
    tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    frame(1'b0, 1'b0, 1'b0, 0, 1'b0);

    repeat (5) put_quiet();
    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
